// File: rtl/vector_descrambler_if.sv
// Streaming handshake bundle for the x^7+x^6+1 descrambler: input word stream,
// output word stream and the resync/lock sideband.
interface vector_descrambler_if #(
    parameter int SIZE = 8
);
    logic [SIZE-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            resync;
    logic            locked;

    modport master (
        output in_data, in_valid, out_ready, resync,
        input  in_ready, out_data, out_valid, locked
    );

    modport slave (
        input  in_data, in_valid, out_ready, resync,
        output in_ready, out_data, out_valid, locked
    );
endinterface

// File: rtl/vector_descrambler.sv
// Self-synchronising x^7+x^6+1 word descrambler with SYNC/HUNT/LOCKED idle detection
// and a single registered output stage.
module vector_descrambler #(
    parameter int SIZE       = 8,
    parameter int LOCK_COUNT = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    vector_descrambler_if.slave bus
);
    typedef enum logic [1:0] {SYNC, HUNT, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [6:0]      h, h_nxt;
    logic [7:0]      zero_cnt, zero_cnt_nxt;
    logic [SIZE-1:0] out_data_q, out_data_nxt;
    logic            out_valid_q, out_valid_nxt;
    logic            locked_q;
    logic            rdy_en;
    logic [SIZE+6:0] ext;
    logic [SIZE-1:0] descr;
    logic            accept;

    // rdy_en keeps the input closed during reset and for the first cycle after it
    assign bus.in_ready  = rdy_en & ~bus.resync & (~out_valid_q | bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.locked    = locked_q;

    // ext lays the 7 history bits below bit 0 in arrival order: ext[k+7] = s[k]
    always_comb begin
        ext   = {bus.in_data, 7'b0};
        descr = '0;
        for (int unsigned j = 0; j < 7; j++) begin
            ext[6-j] = h[j];
        end
        for (int unsigned k = 0; k < SIZE; k++) begin
            descr[k] = ext[k+7] ^ ext[k+1] ^ ext[k];
        end
    end

    always_comb begin
        state_nxt     = state;
        h_nxt         = h;
        zero_cnt_nxt  = zero_cnt;
        out_data_nxt  = out_data_q;
        out_valid_nxt = out_valid_q & ~bus.out_ready;
        if (bus.resync) begin
            state_nxt    = SYNC;
            h_nxt        = '0;
            zero_cnt_nxt = '0;
        end else if (accept) begin
            for (int unsigned j = 0; j < 7; j++) begin
                h_nxt[j] = bus.in_data[SIZE-1-j];
            end
            case (state)
                SYNC: state_nxt = HUNT;
                HUNT: begin
                    out_data_nxt  = descr;
                    out_valid_nxt = 1'b1;
                    if (descr != '0) begin
                        zero_cnt_nxt = '0;
                    end else if (zero_cnt != 8'(LOCK_COUNT)) begin
                        zero_cnt_nxt = zero_cnt + 8'd1;
                    end
                    if (zero_cnt_nxt == 8'(LOCK_COUNT)) begin
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    out_data_nxt  = descr;
                    out_valid_nxt = 1'b1;
                end
                default: state_nxt = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SYNC;
            h           <= '0;
            zero_cnt    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            rdy_en      <= 1'b0;
        end else begin
            state       <= state_nxt;
            h           <= h_nxt;
            zero_cnt    <= zero_cnt_nxt;
            out_data_q  <= out_data_nxt;
            out_valid_q <= out_valid_nxt;
            locked_q    <= (state_nxt == LOCKED);
            rdy_en      <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vector_descrambler.sv
// Directed bench: a serial scrambler model feeds the descrambler; an expected-word
// queue checks every delivered output word.
module tb_vector_descrambler;
    logic clk;
    logic rst_n;

    vector_descrambler_if #(.SIZE(8)) bus ();

    vector_descrambler #(.SIZE(8), .LOCK_COUNT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  exp_q[$];
    logic [6:0]  hist = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // serial scrambler: sr[0] is the most recently sent scrambled bit
    function automatic logic [7:0] scr(input logic [7:0] p);
        logic [6:0] sr;
        logic [7:0] s;
        sr = hist;
        s  = '0;
        for (int k = 0; k < 8; k++) begin
            s[k] = p[k] ^ sr[5] ^ sr[6];
            sr   = {sr[5:0], s[k]};
        end
        return s;
    endfunction

    task automatic push(input logic [7:0] s);
        int unsigned n;
        n = 0;
        bus.in_data  = s;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) hist = {hist[5:0], s[k]};
    endtask

    task automatic send_plain(input logic [7:0] p);
        logic [7:0] s;
        s = scr(p);
        exp_q.push_back(p);
        push(s);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("out_unexpected", 64'(bus.out_valid), 64'd0);
            else check("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [7:0] s2, sx;
        int unsigned n;
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.resync    = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_locked", 64'(bus.locked), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        #21 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // raw 0x00 (SYNC, silent) then 0xFF -> 0xBF one cycle later
        push(8'h00);
        check("sync_no_out", 64'(bus.out_valid), 64'd0);
        exp_q.push_back(8'hBF);
        push(8'hFF);
        check("ff_valid", 64'(bus.out_valid), 64'd1);
        check("ff_data", 64'(bus.out_data), 64'hBF);

        // idle stream: lock after the 4th zero word in HUNT
        for (int i = 1; i <= 4; i++) begin
            send_plain(8'h00);
            check($sformatf("idle_locked_%0d", i), 64'(bus.locked), 64'(i == 4));
        end

        // stall: out_ready low for 5 cycles with a word waiting
        send_plain(8'hA5);
        bus.out_ready = 1'b0;
        s2 = scr(8'h3C);
        exp_q.push_back(8'h3C);
        bus.in_data  = s2;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_out_data", 64'(bus.out_data), 64'hA5);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        push(s2);
        send_plain(8'hC3);

        // resync while LOCKED with a word offered in the same cycle
        send_plain(8'h00);
        sx = 8'($urandom_range(0, 255));
        bus.resync   = 1'b1;
        bus.in_data  = sx;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("resync_in_ready", 64'(bus.in_ready), 64'd0);
        check("resync_locked_pre", 64'(bus.locked), 64'd1);
        @(posedge clk);
        #1;
        bus.resync = 1'b0;
        check("resync_locked_post", 64'(bus.locked), 64'd0);
        push(sx);
        check("resync_sync_silent", 64'(bus.out_valid), 64'd0);

        // random stream: 3 zeros, a nonzero word, then 4 fresh zeros to lock
        for (int i = 0; i < 2; i++) send_plain(8'($urandom_range(1, 255)));
        for (int i = 0; i < 3; i++) begin
            send_plain(8'h00);
            check("pre_break_locked", 64'(bus.locked), 64'd0);
        end
        send_plain(8'h5A);
        check("break_locked", 64'(bus.locked), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            send_plain(8'h00);
            check($sformatf("relock_%0d", i), 64'(bus.locked), 64'(i == 4));
        end

        // asynchronous reset while a word is pending on the output
        send_plain(8'h77);
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_locked", 64'(bus.locked), 64'd0);
        check("async_out_data", 64'(bus.out_data), 64'd0);
        check("async_in_ready", 64'(bus.in_ready), 64'd0);
        exp_q.delete();
        bus.in_data  = 8'h96;
        bus.in_valid = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd0);
        push(8'h96);
        check("post_rst_sync_silent", 64'(bus.out_valid), 64'd0);
        send_plain(8'h12);
        send_plain(8'h34);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vector_descrambler.md
VECTOR_DESCRAMBLER -- requirements
Module: vector_descrambler

Interface
REQ-001 SHALL have parameter SIZE, default 8, giving the data word width in bits; the legal range is 8..64.
REQ-002 SHALL have parameter LOCK_COUNT, default 4, giving the number of consecutive all-zero descrambled words needed to declare lock; the legal range is 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data, input, SIZE bits: the scrambled word; bit 0 is the earliest bit in time.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-008 SHALL have port out_data, output, SIZE bits: the descrambled word; bit 0 is the earliest bit in time.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts out_data.
REQ-011 SHALL have port resync, input, 1 bit: single-cycle request to restart synchronisation.
REQ-012 SHALL have port locked, output, 1 bit: the idle pattern has been detected and lock declared.

Function
REQ-013 SHALL implement the self-synchronising descrambler for x^7+x^6+1: d[k] = s[k] ^ s[k-6] ^ s[k-7].
REQ-014 SHALL take s[k-6] and s[k-7] for k<7 from a 7-bit history register h, where h[j] holds the scrambled bit received j+1 positions before bit 0 of the current word.
REQ-015 SHALL, on each accepted word (in_valid & in_ready), load h with bits SIZE-1..SIZE-7 of in_data so that h[0] = in_data[SIZE-1].
REQ-016 SHALL hold h when no word is accepted.
REQ-017 SHALL drive in_ready = ~resync & (~out_valid | out_ready) (single output register, no bubble on back-to-back transfers).
REQ-018 SHALL implement an FSM with three states:
  - SYNC: the first accepted word loads h only, produces no output, and moves the FSM to HUNT.
  - HUNT: every accepted word is descrambled into the output register. A descrambled 0 increments zero_cnt; a nonzero word clears it. When zero_cnt reaches LOCK_COUNT, the FSM moves to LOCKED.
  - LOCKED: words pass through descrambled, and the FSM remains in LOCKED until resync or reset.
REQ-019 SHALL assert locked in the cycle after the accepted word that brings zero_cnt to LOCK_COUNT, i.e. registered with the FSM state.
REQ-020 SHALL have a latency of one clock from an accepted input to out_valid=1 with that word on out_data, in HUNT and LOCKED only.
REQ-021 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, when out_valid & out_ready are high and no new word is accepted, deassert out_valid on the next edge.
REQ-023 SHALL, on resync=1:
  - accept no input in that cycle;
  - clear h and zero_cnt;
  - deassert locked;
  - enter SYNC on the next edge.
REQ-024 SHALL, on resync, leave a pending out_valid word held and deliverable to the downstream consumer.
REQ-025 SHALL saturate zero_cnt at LOCK_COUNT, with no wrap-around.
REQ-026 SHALL make all outputs registered except in_ready.

Reset
REQ-027 SHALL, while rst_n=0, immediately force:
  - state = SYNC;
  - h = 0;
  - zero_cnt = 0;
  - out_data = 0;
  - out_valid = 0;
  - locked = 0.
REQ-028 SHALL, while rst_n=0, hold in_ready at 0.
REQ-029 SHALL accept no input in the first cycle after rst_n deasserts.
REQ-030 SHALL discard a word in flight, and return to SYNC, if rst_n asserts mid-transfer.

Verification
REQ-031 SHALL be covered by a bench with SIZE=8 and out_ready=1 for these directed scenarios:
  - After reset, send 0x00 then 0xFF: no output for 0x00; the output for 0xFF is 0xBF, one cycle later.
  - A scrambler model feeds all-zero data after the first word: out_data is 0x00 and locked rises after the 4th HUNT word.
  - In a random stream, a nonzero descrambled word arrives after 3 zero words: zero_cnt clears, locked stays 0, and lock is declared only after 4 new consecutive zero words.
  - Hold out_ready=0 for 5 cycles while in_valid=1: out_data is held, in_ready=0, and no word is lost or duplicated after release; the output sequence matches the model.
  - Pulse resync while LOCKED, with in_valid=1 in that cycle: in_ready=0 in that cycle; locked falls next cycle; the next word is consumed silently (SYNC) and output resumes from the following word.
  - Assert rst_n=0 mid-stream with out_valid=1: out_valid, locked and out_data go to 0 without waiting for a clock edge.
